// File: rtl/time_set_ctrl.sv
// Push-button time editor: debounces five buttons, edits a copy of the live
// time and hands it to the time counter with a one-cycle load pulse.
module time_set_ctrl #(
    parameter int DEB_TICKS  = 4,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       msec_tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       middle,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic       editing,
    output logic [1:0] field,
    output logic       blink
);
    // state  | meaning
    // IDLE   | not editing, field=0, waits for a middle press
    // EDIT   | set_* being edited, timeout and blink timers running
    // COMMIT | single cycle with load=1, then back to IDLE
    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_MS - 1);
    localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_MS - 1);

    logic [4:0]    btn_raw, sync_a, sync_b, deb, deb_q, press;
    logic [DW-1:0] deb_cnt [5];
    logic          ev_mid, ev_up, ev_dn, ev_lt, ev_rt, ev_any;

    assign btn_raw = {middle, up, down, left, right};
    assign press   = deb & ~deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            deb_q  <= deb;
            if (msec_tick) begin
                for (int i = 0; i < 5; i++) begin
                    if (sync_b[i] == deb[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync_b[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end
            end
        end
    end

    // Fixed priority: middle > up > down > left > right.
    assign ev_mid = press[4];
    assign ev_up  = press[3] & ~press[4];
    assign ev_dn  = press[2] & ~|press[4:3];
    assign ev_lt  = press[1] & ~|press[4:2];
    assign ev_rt  = press[0] & ~|press[4:1];
    assign ev_any = |press;

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] max_v,
                                       input logic inc);
        if (inc) return (v == max_v) ? 6'd0 : v + 6'd1;
        else     return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

    state_t        state, state_nx;
    logic [4:0]    hour_nx;
    logic [5:0]    min_nx, sec_nx;
    logic [1:0]    field_nx;
    logic          blink_nx;
    logic [TW-1:0] to_cnt, to_nx;
    logic [BW-1:0] bl_cnt, bl_nx;

    always_comb begin
        state_nx = state;
        hour_nx  = set_hour;
        min_nx   = set_min;
        sec_nx   = set_sec;
        field_nx = field;
        blink_nx = blink;
        to_nx    = to_cnt;
        bl_nx    = bl_cnt;
        case (state)
            IDLE: begin
                field_nx = 2'd0;
                blink_nx = 1'b0;
                if (ev_mid) begin
                    state_nx = EDIT;
                    hour_nx  = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                    min_nx   = (cur_min > 6'd59) ? 6'd0 : cur_min;
                    sec_nx   = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
                    field_nx = 2'd3;
                    to_nx    = '0;
                    bl_nx    = '0;
                end
            end
            EDIT: begin
                if (ev_any) begin
                    to_nx    = '0;
                    bl_nx    = '0;
                    blink_nx = 1'b0;
                    if (ev_mid) begin
                        state_nx = COMMIT;
                        field_nx = 2'd0;
                    end else if (ev_up || ev_dn) begin
                        case (field)
                            2'd1:    sec_nx  = step(set_sec, 6'd59, ev_up);
                            2'd2:    min_nx  = step(set_min, 6'd59, ev_up);
                            default: hour_nx = 5'(step({1'b0, set_hour}, 6'd23, ev_up));
                        endcase
                    end else if (ev_lt) begin
                        field_nx = (field == 2'd3) ? 2'd1 : field + 2'd1;
                    end else if (ev_rt) begin
                        field_nx = (field == 2'd1) ? 2'd3 : field - 2'd1;
                    end
                end else if (msec_tick) begin
                    if (bl_cnt == BL_LAST) begin
                        bl_nx    = '0;
                        blink_nx = ~blink;
                    end else begin
                        bl_nx = bl_cnt + BW'(1);
                    end
                    // Timeout overrides the blink update: abort without loading.
                    if (to_cnt == TO_LAST) begin
                        state_nx = IDLE;
                        field_nx = 2'd0;
                        blink_nx = 1'b0;
                    end else begin
                        to_nx = to_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                field_nx = 2'd0;
                blink_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            set_hour <= '0;
            set_min  <= '0;
            set_sec  <= '0;
            field    <= '0;
            blink    <= 1'b0;
            load     <= 1'b0;
            editing  <= 1'b0;
            to_cnt   <= '0;
            bl_cnt   <= '0;
        end else begin
            state    <= state_nx;
            set_hour <= hour_nx;
            set_min  <= min_nx;
            set_sec  <= sec_nx;
            field    <= field_nx;
            blink    <= blink_nx;
            load     <= (state_nx == COMMIT);
            editing  <= (state_nx == EDIT);
            to_cnt   <= to_nx;
            bl_cnt   <= bl_nx;
        end
    end
endmodule
